// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Unified hazard controller for a 5-stage MIPS pipeline.
//                Operand forwarding select, load-use stall, branch flush,
//                multi-cycle MUL/DIV hold, saturating stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int RA_W   = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic [RA_W-1:0]  ex_rs,
   input  logic [RA_W-1:0]  ex_rt,
   input  logic             ex_memread,
   input  logic             ex_md,
   input  logic [RA_W-1:0]  mem_rd,
   input  logic             mem_regwr,
   input  logic [RA_W-1:0]  wb_rd,
   input  logic             wb_regwr,
   input  logic             br_taken,
   input  logic             perf_clr,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             stall_idex,
   output logic             bubble_ex,
   output logic             bubble_mem,
   output logic             flush,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // The countdown only ever holds MD_LAT-2; keep at least one bit so the
   // MD_LAT==1 and MD_LAT==2 builds still elaborate.
   localparam int              MDC_W      = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
   localparam logic [MDC_W-1:0] c_MDC_INIT = (MD_LAT > 1) ? MDC_W'(MD_LAT - 2) : '0;
   localparam logic            c_MD_EN    = (MD_LAT > 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   localparam logic [0:0] c_ST_IDLE   = 1'b0;
   localparam logic [0:0] c_ST_MD_RUN = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [MDC_W-1:0] mdc_q, mdc_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             w_lu;
   logic             w_run;

   // Load-use: the load in EX targets a source of the instruction in ID.
   assign w_lu  = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
   assign w_run = (state_q == c_ST_MD_RUN);

   // Forwarding select: newest producer (EX/MEM) wins, r0 is never forwarded.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (mem_regwr && (mem_rd != '0) && (mem_rd == ex_rs))
         fwd_a = 2'b10;
      else if (wb_regwr && (wb_rd != '0) && (wb_rd == ex_rs))
         fwd_a = 2'b01;
      if (mem_regwr && (mem_rd != '0) && (mem_rd == ex_rt))
         fwd_b = 2'b10;
      else if (wb_regwr && (wb_rd != '0) && (wb_rd == ex_rt))
         fwd_b = 2'b01;
   end

   // MUL/DIV state register and remaining-cycle countdown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= c_ST_IDLE;
         mdc_q   <= '0;
      end else begin
         state_q <= state_d;
         mdc_q   <= mdc_d;
      end
   end

   // Next state: the first EX cycle of a MUL/DIV is spent in IDLE, the rest
   // in MD_RUN; a taken branch aborts the operation.
   always_comb begin
      state_d = state_q;
      mdc_d   = mdc_q;
      case (state_q)
         c_ST_IDLE: begin
            if (ex_md && !br_taken && c_MD_EN) begin
               state_d = c_ST_MD_RUN;
               mdc_d   = c_MDC_INIT;
            end
         end
         c_ST_MD_RUN: begin
            if (br_taken) begin
               state_d = c_ST_IDLE;
               mdc_d   = '0;
            end else if (mdc_q == '0) begin
               state_d = c_ST_IDLE;
            end else begin
               mdc_d = mdc_q - MDC_W'(1);
            end
         end
         default: begin
            state_d = c_ST_IDLE;
            mdc_d   = '0;
         end
      endcase
   end

   // Pipeline controls: flush overrides everything, MD_RUN overrides load-use.
   always_comb begin
      stall_pc   = 1'b0;
      stall_ifid = 1'b0;
      stall_idex = 1'b0;
      bubble_ex  = 1'b0;
      bubble_mem = 1'b0;
      flush      = br_taken;
      md_busy    = w_run;
      if (!br_taken) begin
         if (w_run) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            stall_idex = 1'b1;
            bubble_mem = 1'b1;
         end else if (w_lu) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            bubble_ex  = 1'b1;
         end
      end
   end

   // Counter update: clear beats increment, increments saturate.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (perf_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_pc && (stall_cnt_q != c_CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (flush && (flush_cnt_q != c_CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl (directed + random
//                stimulus against a behavioural reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int MD_LAT = 4;
   localparam int MAX_W  = 65535;
   localparam int MAX_S  = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
   logic       ex_memread, ex_md, mem_regwr, wb_regwr, br_taken, perf_clr;

   logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
   logic        stall_pc, stall_ifid, stall_idex, bubble_ex, bubble_mem, flush, md_busy;
   logic        s_stall_pc, s_stall_ifid, s_stall_idex, s_bubble_ex, s_bubble_mem, s_flush, s_md_busy;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int busy_left;
   int m_scnt, m_fcnt, m_scnt_s, m_fcnt_s;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RA_W(5), .MD_LAT(MD_LAT), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_memread(ex_memread), .ex_md(ex_md),
      .mem_rd(mem_rd), .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
      .br_taken(br_taken), .perf_clr(perf_clr),
      .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
      .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .flush(flush), .md_busy(md_busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.RA_W(5), .MD_LAT(MD_LAT), .CNT_W(2)) dut_s (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_memread(ex_memread), .ex_md(ex_md),
      .mem_rd(mem_rd), .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
      .br_taken(br_taken), .perf_clr(perf_clr),
      .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
      .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .stall_idex(s_stall_idex),
      .bubble_ex(s_bubble_ex), .bubble_mem(s_bubble_mem), .flush(s_flush), .md_busy(s_md_busy),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (mem_regwr && mem_rd != 0 && mem_rd == src) return 2'b10;
      if (wb_regwr && wb_rd != 0 && wb_rd == src)    return 2'b01;
      return 2'b00;
   endfunction

   function automatic int sat_inc(input int v, input int mx);
      return (v >= mx) ? mx : v + 1;
   endfunction

   task automatic zero_inputs();
      id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; mem_rd = 0; wb_rd = 0;
      ex_memread = 0; ex_md = 0; mem_regwr = 0; wb_regwr = 0; br_taken = 0; perf_clr = 0;
   endtask

   task automatic model_reset();
      busy_left = 0; m_scnt = 0; m_fcnt = 0; m_scnt_s = 0; m_fcnt_s = 0;
   endtask

   // Inputs are applied at the falling edge; outputs are checked 1 time unit
   // later, the model is advanced for the coming rising edge, then we wait for
   // the next falling edge.
   task automatic step(input string tag);
      logic busy, lu, br, e_stall, e_idex, e_bex, e_bmem;
      #1;
      busy    = (busy_left > 0);
      br      = br_taken;
      lu      = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
      e_stall = !br && (busy || lu);
      e_idex  = !br && busy;
      e_bex   = !br && !busy && lu;
      e_bmem  = !br && busy;
      chk({tag, ":fwd_a"},      fwd_a,      ref_fwd(ex_rs));
      chk({tag, ":fwd_b"},      fwd_b,      ref_fwd(ex_rt));
      chk({tag, ":stall_pc"},   stall_pc,   e_stall);
      chk({tag, ":stall_ifid"}, stall_ifid, e_stall);
      chk({tag, ":stall_idex"}, stall_idex, e_idex);
      chk({tag, ":bubble_ex"},  bubble_ex,  e_bex);
      chk({tag, ":bubble_mem"}, bubble_mem, e_bmem);
      chk({tag, ":flush"},      flush,      br);
      chk({tag, ":md_busy"},    md_busy,    busy);
      chk({tag, ":stall_cnt"},  stall_cnt,  m_scnt);
      chk({tag, ":flush_cnt"},  flush_cnt,  m_fcnt);
      chk({tag, ":s_stall_cnt"}, s_stall_cnt, m_scnt_s);
      chk({tag, ":s_flush_cnt"}, s_flush_cnt, m_fcnt_s);
      chk({tag, ":s_stall_pc"},  s_stall_pc,  e_stall);
      // model advance at the rising edge
      if (perf_clr) begin
         m_scnt = 0; m_fcnt = 0; m_scnt_s = 0; m_fcnt_s = 0;
      end else begin
         if (e_stall) begin m_scnt = sat_inc(m_scnt, MAX_W); m_scnt_s = sat_inc(m_scnt_s, MAX_S); end
         if (br)      begin m_fcnt = sat_inc(m_fcnt, MAX_W); m_fcnt_s = sat_inc(m_fcnt_s, MAX_S); end
      end
      if (busy)
         busy_left = br ? 0 : busy_left - 1;
      else if (ex_md && !br && MD_LAT > 1)
         busy_left = MD_LAT - 1;
      @(negedge clk);
   endtask

   initial begin
      int nbusy;
      reset = 1'b1;
      zero_inputs();
      model_reset();
      @(negedge clk);
      #1;
      chk("rst:fwd_a", fwd_a, 0);       chk("rst:fwd_b", fwd_b, 0);
      chk("rst:stall_pc", stall_pc, 0); chk("rst:flush", flush, 0);
      chk("rst:md_busy", md_busy, 0);   chk("rst:stall_cnt", stall_cnt, 0);
      chk("rst:flush_cnt", flush_cnt, 0);
      @(negedge clk);
      reset = 1'b0;
      step("idle");

      // Both producers match: EX/MEM wins.
      mem_regwr = 1; mem_rd = 5; ex_rs = 5; ex_rt = 5; wb_regwr = 1; wb_rd = 5;
      #1; chk("fwd_both:a", fwd_a, 2'b10); chk("fwd_both:b", fwd_b, 2'b10);
      step("fwd_both");

      // r0 never forwarded; MEM/WB used when EX/MEM does not match.
      zero_inputs();
      mem_rd = 0; mem_regwr = 1; wb_rd = 7; wb_regwr = 1; ex_rs = 0; ex_rt = 7;
      #1; chk("fwd_r0:a", fwd_a, 2'b00); chk("fwd_r0:b", fwd_b, 2'b01);
      step("fwd_r0");

      // Load-use for one cycle.
      zero_inputs();
      ex_memread = 1; ex_rt = 8; id_rs = 8;
      #1; chk("lu:bubble_ex", bubble_ex, 1);
      step("lu");
      zero_inputs();
      #1; chk("lu:stall_cnt_after", stall_cnt, 1);
      step("lu_after");

      // Load-use plus taken branch: flush wins.
      ex_memread = 1; ex_rt = 8; id_rs = 8; br_taken = 1;
      #1; chk("lu_br:stall_pc", stall_pc, 0);
      step("lu_br");
      zero_inputs();
      #1; chk("lu_br:flush_cnt", flush_cnt, 1); chk("lu_br:stall_cnt", stall_cnt, 1);
      step("lu_br_after");

      // MUL/DIV: busy exactly MD_LAT-1 cycles.
      perf_clr = 1;
      step("clr0");
      zero_inputs();
      ex_md = 1;
      step("md_start");
      zero_inputs();
      nbusy = 0;
      for (int i = 0; i < 5; i++) begin
         #1; nbusy += int'(md_busy);
         step("md_run");
      end
      chk("md:busy_cycles", nbusy, 3);
      #1; chk("md:stall_cnt", stall_cnt, 3);
      step("md_done");

      // MUL/DIV aborted by branch in second busy cycle.
      ex_md = 1;
      step("md2_start");
      zero_inputs();
      step("md2_busy1");
      br_taken = 1;
      step("md2_busy2_br");
      zero_inputs();
      #1; chk("md2:idle_after_br", md_busy, 0);
      step("md2_after");

      // Saturation of the narrow counter, then clear.
      perf_clr = 1;
      step("clr1");
      zero_inputs();
      ex_memread = 1; ex_rt = 3; id_rt = 3;
      for (int i = 0; i < 6; i++) step("lu_hold");
      zero_inputs();
      #1; chk("sat:s_stall_cnt", s_stall_cnt, 3); chk("sat:stall_cnt", stall_cnt, 6);
      perf_clr = 1;
      step("clr2");
      zero_inputs();
      #1; chk("clr:s_stall_cnt", s_stall_cnt, 0); chk("clr:stall_cnt", stall_cnt, 0);
      step("clr_after");

      // Reset in the middle of MD_RUN drops stalls immediately.
      ex_md = 1;
      step("md3_start");
      zero_inputs();
      step("md3_busy1");
      #2; reset = 1'b1; #1;
      chk("rst_mid:md_busy", md_busy, 0);
      chk("rst_mid:stall_pc", stall_pc, 0);
      chk("rst_mid:stall_idex", stall_idex, 0);
      chk("rst_mid:bubble_mem", bubble_mem, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step("post_rst");

      // Randomized phase with a small register range to provoke matches.
      for (int i = 0; i < 400; i++) begin
         id_rs      = 5'($urandom_range(0, 3));
         id_rt      = 5'($urandom_range(0, 3));
         ex_rs      = 5'($urandom_range(0, 3));
         ex_rt      = 5'($urandom_range(0, 3));
         mem_rd     = 5'($urandom_range(0, 3));
         wb_rd      = 5'($urandom_range(0, 3));
         mem_regwr  = 1'($urandom_range(0, 1));
         wb_regwr   = 1'($urandom_range(0, 1));
         ex_memread = ($urandom_range(0, 2) == 0);
         ex_md      = ($urandom_range(0, 9) == 0);
         br_taken   = ($urandom_range(0, 11) == 0);
         perf_clr   = ($urandom_range(0, 40) == 0);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
